// File: rtl/mc_fetch_mem_unit.sv
// Fetch/memory stage of the multi-cycle core: owns PC, IR and MDR, runs the
// unified memory handshake with timeout, and stalls the controller while busy.
module mc_fetch_mem_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        Branch2,
  input  logic [1:0]  PCSrc,
  input  logic        IRWrite,
  input  logic        lorD,
  input  logic        MemWrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] wr_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        stall,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        bus_error,
  output logic        align_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout_hit;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_mdr;
  logic        r_bus_error;
  logic        r_align_error;

  logic        w_acc;
  logic        w_fetch;
  logic        w_load;
  logic        w_store;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_pc_en;
  logic [31:0] w_pc_tgt;
  logic [31:0] w_pc_nxt;
  logic        w_misalign;

  // Access decode; lorD overrides a simultaneous IRWrite.
  assign w_acc   = IRWrite | lorD;
  assign w_fetch = IRWrite & ~lorD;
  assign w_load  = lorD & ~MemWrite;
  assign w_store = lorD & MemWrite;

  assign mem_req   = w_acc;
  assign mem_we    = w_store & w_acc;
  assign mem_addr  = lorD ? alu_out : r_pc;
  assign mem_wdata = wr_data;
  assign stall     = w_acc & ~mem_ready & ~w_timeout_hit;

  // A timed-out access completes with zero data so the controller can proceed.
  assign w_done  = w_acc & (mem_ready | w_timeout_hit);
  assign w_rdata = mem_ready ? mem_rdata : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !mem_ready) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (!w_acc || mem_ready) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // PC target select; low bits are forced to word alignment.
  always_comb begin
    w_pc_tgt = r_pc;
    case (PCSrc)
      2'b00:   w_pc_tgt = alu_result;
      2'b01:   w_pc_tgt = alu_out;
      2'b10:   w_pc_tgt = {r_pc[31:28], r_instr[25:0], 2'b00};
      default: w_pc_tgt = r_pc;
    endcase
  end

  assign w_misalign = |w_pc_tgt[1:0];
  assign w_pc_nxt   = {w_pc_tgt[31:2], 2'b00};
  assign w_pc_en    = (PCWrite | (Branch & zero) | (Branch2 & ~zero)) & ~stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_mdr         <= 32'h0;
      r_bus_error   <= 1'b0;
      r_align_error <= 1'b0;
    end else begin
      if (w_pc_en) begin
        r_pc <= w_pc_nxt;
        if (w_misalign) r_align_error <= 1'b1;
      end
      if (w_done && w_fetch) r_instr <= w_rdata;
      if (w_done && w_load)  r_mdr   <= w_rdata;
      if (w_timeout_hit)     r_bus_error <= 1'b1;
    end
  end

  assign pc          = r_pc;
  assign instr       = r_instr;
  assign mdr         = r_mdr;
  assign bus_error   = r_bus_error;
  assign align_error = r_align_error;

  assign op    = r_instr[31:26];
  assign rs    = r_instr[25:21];
  assign rt    = r_instr[20:16];
  assign rd    = r_instr[15:11];
  assign shamt = r_instr[10:6];
  assign funct = r_instr[5:0];
  assign imm   = r_instr[15:0];

endmodule

// File: tb/tb_mc_fetch_mem_unit.sv
// Directed bench for mc_fetch_mem_unit: fetch, waits, branches, jump,
// alignment, load/store, abort, timeout and reset during a wait.
module tb_mc_fetch_mem_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite, Branch, Branch2, IRWrite, lorD, MemWrite, zero, mem_ready;
  logic [1:0]  PCSrc;
  logic [31:0] alu_result, alu_out, wr_data, mem_rdata;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
  logic        mem_req, mem_we, stall, bus_error, align_error;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mc_fetch_mem_unit #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .Branch(Branch),
    .Branch2(Branch2), .PCSrc(PCSrc), .IRWrite(IRWrite), .lorD(lorD),
    .MemWrite(MemWrite), .zero(zero), .alu_result(alu_result),
    .alu_out(alu_out), .wr_data(wr_data), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .stall(stall), .pc(pc),
    .instr(instr), .mdr(mdr), .op(op), .funct(funct), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .imm(imm), .bus_error(bus_error),
    .align_error(align_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    PCWrite = 0; Branch = 0; Branch2 = 0; PCSrc = 2'b00; IRWrite = 0;
    lorD = 0; MemWrite = 0; zero = 0; mem_ready = 0;
  endtask

  initial begin
    reset = 1; quiet();
    alu_result = 0; alu_out = 0; wr_data = 0; mem_rdata = 0;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    check("rst_align_error", 32'(align_error), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // Zero-wait fetch
    @(negedge clock);
    reset = 0; IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h4;
    mem_rdata = 32'h2008_0005; mem_ready = 1;
    #1;
    check("zw_stall", 32'(stall), 32'h0);
    check("zw_mem_req", 32'(mem_req), 32'h1);
    check("zw_mem_addr", mem_addr, 32'h0);
    check("zw_mem_we", 32'(mem_we), 32'h0);
    tick();
    check("zw_instr", instr, 32'h2008_0005);
    check("zw_pc", pc, 32'h4);
    check("zw_op", 32'(op), 32'd8);
    check("zw_rt", 32'(rt), 32'd8);
    check("zw_imm", 32'(imm), 32'h5);

    // 3-wait fetch
    @(negedge clock);
    mem_ready = 0; mem_rdata = 32'h1111_2222; alu_result = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("w3_stall", 32'(stall), 32'h1);
      check("w3_mem_addr", mem_addr, 32'h4);
      tick();
      check("w3_pc_hold", pc, 32'h4);
      check("w3_instr_hold", instr, 32'h2008_0005);
      @(negedge clock);
    end
    mem_ready = 1;
    #1;
    check("w3_stall_done", 32'(stall), 32'h0);
    tick();
    check("w3_instr", instr, 32'h1111_2222);
    check("w3_pc", pc, 32'h8);

    // Outside an access mem_ready is ignored
    @(negedge clock);
    quiet(); mem_ready = 1;
    #1;
    check("idle_mem_req", 32'(mem_req), 32'h0);
    check("idle_stall", 32'(stall), 32'h0);

    // beq / bne
    @(negedge clock);
    quiet(); Branch = 1; PCSrc = 2'b01; alu_out = 32'h40; zero = 0;
    tick();
    check("beq_nt_pc", pc, 32'h8);
    @(negedge clock);
    zero = 1;
    tick();
    check("beq_t_pc", pc, 32'h40);
    @(negedge clock);
    Branch = 0; Branch2 = 1; alu_out = 32'h80; zero = 1;
    tick();
    check("bne_nt_pc", pc, 32'h40);
    @(negedge clock);
    zero = 0;
    tick();
    check("bne_t_pc", pc, 32'h80);

    // Jump: set pc, fetch a J-type word, then take the jump
    @(negedge clock);
    quiet(); PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h1000_0000;
    tick();
    check("j_pc_set", pc, 32'h1000_0000);
    @(negedge clock);
    quiet(); IRWrite = 1; mem_ready = 1; mem_rdata = 32'h0800_0010;
    #1;
    check("j_fetch_addr", mem_addr, 32'h1000_0000);
    tick();
    check("j_instr", instr, 32'h0800_0010);
    check("j_pc_no_write", pc, 32'h1000_0000);
    @(negedge clock);
    quiet(); PCWrite = 1; PCSrc = 2'b10;
    tick();
    check("j_pc", pc, 32'h1000_0040);
    check("j_align_clean", 32'(align_error), 32'h0);

    // Misaligned target
    @(negedge clock);
    PCSrc = 2'b00; alu_result = 32'h7;
    tick();
    check("al_pc", pc, 32'h4);
    check("al_flag", 32'(align_error), 32'h1);
    @(negedge clock);
    PCSrc = 2'b11;
    tick();
    check("hold_pc", pc, 32'h4);
    check("al_sticky", 32'(align_error), 32'h1);

    // Load
    @(negedge clock);
    quiet(); lorD = 1; alu_out = 32'h80; mem_rdata = 32'hDEAD_BEEF; mem_ready = 1;
    #1;
    check("ld_addr", mem_addr, 32'h80);
    check("ld_we", 32'(mem_we), 32'h0);
    tick();
    check("ld_mdr", mdr, 32'hDEAD_BEEF);
    check("ld_instr_hold", instr, 32'h0800_0010);

    // Store
    @(negedge clock);
    MemWrite = 1; wr_data = 32'hCAFE_F00D; mem_rdata = 32'h1234_5678;
    #1;
    check("st_we", 32'(mem_we), 32'h1);
    check("st_wdata", mem_wdata, 32'hCAFE_F00D);
    tick();
    check("st_mdr_hold", mdr, 32'hDEAD_BEEF);

    // IRWrite and lorD together: load wins, IR untouched
    @(negedge clock);
    MemWrite = 0; IRWrite = 1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("ill_addr", mem_addr, 32'h80);
    tick();
    check("ill_mdr", mdr, 32'h5555_AAAA);
    check("ill_instr", instr, 32'h0800_0010);

    // Abort: controller drops the request during a wait
    @(negedge clock);
    quiet(); IRWrite = 1; mem_rdata = 32'h9999_9999;
    tick();
    @(negedge clock);
    tick();
    @(negedge clock);
    IRWrite = 0; mem_ready = 1;
    #1;
    check("ab_mem_req", 32'(mem_req), 32'h0);
    check("ab_stall", 32'(stall), 32'h0);
    tick();
    check("ab_instr", instr, 32'h0800_0010);

    // Timeout: TIMEOUT-1 stall cycles, then forced zero completion
    @(negedge clock);
    quiet(); IRWrite = 1; mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("to_stall", 32'(stall), 32'h1);
      tick();
      @(negedge clock);
    end
    #1;
    check("to_stall_release", 32'(stall), 32'h0);
    check("to_mem_req", 32'(mem_req), 32'h1);
    check("to_instr_pre", instr, 32'h0800_0010);
    tick();
    check("to_bus_error", 32'(bus_error), 32'h1);
    check("to_instr", instr, 32'h0);
    check("to_pc_hold", pc, 32'h4);

    // Reset in the middle of a wait
    @(negedge clock);
    quiet(); IRWrite = 1;
    tick();
    @(negedge clock);
    tick();
    @(negedge clock);
    quiet(); reset = 1;
    tick();
    check("rw_pc", pc, 32'h0);
    check("rw_instr", instr, 32'h0);
    check("rw_mdr", mdr, 32'h0);
    check("rw_bus_error", 32'(bus_error), 32'h0);
    check("rw_align_error", 32'(align_error), 32'h0);
    check("rw_mem_req", 32'(mem_req), 32'h0);

    // Fresh access after reset completes normally
    @(negedge clock);
    reset = 0; IRWrite = 1; mem_ready = 1; mem_rdata = 32'h0123_4567;
    #1;
    check("post_stall", 32'(stall), 32'h0);
    tick();
    check("post_instr", instr, 32'h0123_4567);
    check("post_funct", 32'(funct), 32'h27);
    check("post_rd", 32'(rd), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_fetch_mem_unit.md
Name: mc_fetch_mem_unit

Overview:
- Datapath stage directly downstream of the multi-cycle controller.
- Owns the PC, the instruction register (IR) and the memory data register (MDR).
- Drives the unified instruction/data memory port with a req/ready handshake, and asserts stall back to the controller to freeze its state register while memory is busy.
- Decodes IR fields for the controller, ALU decoder and register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a bus error is flagged

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
PCWrite  in  1  unconditional PC write (controller)
Branch  in  1  beq: write PC when zero=1
Branch2  in  1  bne: write PC when zero=0
PCSrc  in  2  PC next select
IRWrite  in  1  instruction fetch this cycle
lorD  in  1  1: address = alu_out, data access
MemWrite  in  1  data store this cycle
zero  in  1  ALU zero flag
alu_result  in  32  combinational ALU result (PC+4 during fetch)
alu_out  in  32  registered ALU result (branch target / data address)
wr_data  in  32  store data (register B)
mem_rdata  in  32  memory read data
mem_ready  in  1  memory completes current access
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_req  out  1  access request
mem_we  out  1  write strobe, qualified by mem_req
stall  out  1  freeze controller and all other state writes
pc  out  32  current PC
instr  out  32  IR contents
mdr  out  32  MDR contents
op  out  6  instr[31:26]
funct  out  6  instr[5:0]
rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
shamt  out  5  instr[10:6]
imm  out  16  instr[15:0]
bus_error  out  1  sticky timeout flag
align_error  out  1  sticky misaligned-PC-target flag

Behaviour:
- Reset values: pc=RESET_PC, instr=0, mdr=0, bus_error=0, align_error=0, timeout counter=0, FSM=IDLE. Combinationally this gives mem_req=0, mem_we=0, stall=0.
- Access request: acc = IRWrite | lorD.
- Access kind: fetch = IRWrite & ~lorD; load = lorD & ~MemWrite; store = lorD & MemWrite. IRWrite & lorD together is illegal; lorD wins and IR is not written.
- mem_addr = lorD ? alu_out : pc.
- mem_wdata = wr_data.
- mem_we = store & mem_req.
- FSM states are IDLE and WAIT.
  - mem_req = acc (combinational) in both states.
  - stall = acc & ~mem_ready & ~timeout_hit.
- IDLE:
  - acc & mem_ready: single-cycle completion; stay IDLE.
  - acc & ~mem_ready: go to WAIT; counter = 1.
- WAIT:
  - Each cycle with ~mem_ready, counter++.
  - mem_ready: completion; return to IDLE; counter = 0.
  - counter == TIMEOUT-1 with ~mem_ready: timeout_hit = 1 that cycle. Completion is forced with read data taken as 32'h0, bus_error set, return to IDLE.
  - acc deasserting while in WAIT (controller misuse): abort, return to IDLE, no register update.
- Completion edge:
  - fetch: instr <= mem_rdata.
  - load: mdr <= mem_rdata.
  - store: no register update.
  - Latency: data is visible on instr/mdr the cycle after mem_ready.
- PC update: pc_en = (PCWrite | (Branch & zero) | (Branch2 & ~zero)) & ~stall.
- PC next by PCSrc:
  - 00: alu_result.
  - 01: alu_out.
  - 10: {pc[31:28], instr[25:0], 2'b00}.
  - 11: pc (hold).
- Alignment: a PC target with bits[1:0] != 0 is loaded with bits[1:0] cleared, and align_error is set (sticky).
- Fetch write-back: PCWrite & IRWrite together (fetch cycle) update the PC at the same edge as the IR, only on completion. The IR captures the word at the old pc.
- Field outputs are pure combinational slices of instr.
- Sticky flags clear only on reset.
- Reset mid-WAIT: return to IDLE, drop mem_req next cycle; no partial latch.
- Outside an access (acc=0), mem_ready is ignored.

Test Plan:
- Zero-wait fetch: reset, IRWrite=PCWrite=1, PCSrc=00, alu_result=4, mem_rdata=32'h2008_0005, mem_ready=1 -> next cycle instr=32'h2008_0005, pc=4, op=6'd8, stall never high.
- 3-wait fetch: mem_ready low for 3 cycles -> stall high exactly 3 cycles, pc and instr unchanged until the edge after mem_ready, then update.
- Branches: Branch=1, PCSrc=01, alu_out=32'h40 with zero=0 -> pc holds; with zero=1 -> pc=32'h40. Branch2 gives the inverse result.
- Jump and alignment: pc=32'h1000_0000, instr[25:0]=26'h10, PCSrc=10, PCWrite=1 -> pc=32'h1000_0040. Then alu_result=32'h7, PCSrc=00 -> pc=4, align_error=1.
- Load/store: lorD=1, alu_out=32'h80, mem_rdata=32'hDEAD_BEEF -> mem_addr=32'h80, mdr=32'hDEAD_BEEF. Store -> mem_we=1 with mem_wdata=wr_data, mdr unchanged.
- Timeout and reset: mem_ready held low -> stall high for TIMEOUT-1 cycles, then bus_error=1 and instr=0. Reset asserted mid-WAIT -> all registers to reset values the next cycle.
